// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback
// and decodes ALU control, with an optional memory wait-state handshake.
module multicycle_control_fsm #(
    parameter int unsigned OP_W     = 7,
    parameter bit          MEM_WAIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            adr_src,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_ctrl,
    output logic            illegal
);

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, JALR, ILLEGAL
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R     = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I     = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(7'b1100111);

    state_t state, state_next;
    logic   mem_done;

    assign mem_done = MEM_WAIT ? mem_ready : 1'b1;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  alu_decode = sub_en ? 3'b001 : 3'b000;
            3'b010:  alu_decode = 3'b101;
            3'b110:  alu_decode = 3'b011;
            3'b111:  alu_decode = 3'b010;
            default: alu_decode = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        illegal    = 1'b0;
        case (state)
            RST: state_next = FETCH;
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_done;
                pc_write   = mem_done;
                if (mem_done) state_next = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECR;
                    OP_I:              state_next = EXECI;
                    OP_BEQ:            state_next = BEQ;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    default:           state_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_done) state_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_done) state_next = FETCH;
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = alu_decode(funct3, funct7b5);
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_ctrl   = alu_decode(funct3, 1'b0);
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = 3'b001;
                pc_write   = zero;
                state_next = FETCH;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = JAL;
            end
            // JAL redirects PC from ALUOut while computing OldPC+4 for the link write
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            ILLEGAL: illegal = 1'b1;
            default: state_next = RST;
        endcase
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle control unit for the RISC-V datapath. It replaces the single-cycle main decoder with a Moore/Mealy state machine that sequences fetch, decode, execute, memory and writeback over several clocks. It generates ALU control from funct fields, supports an optional memory wait-state handshake, and traps unsupported opcodes into a sticky illegal state. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface

Parameters:
- OP_W, 7, opcode width.
- MEM_WAIT, 0, 1 = fetch/load/store states stall until mem_ready; 0 = mem_ready ignored, one cycle per memory state.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  OP_W  instruction opcode (IR[6:0]).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- pc_write  out  1  PC load enable.
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR/OldPC load enable.
- reg_write  out  1  register-file write enable.
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  sticky unsupported-opcode flag.

## Operation

- States: RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR, ILLEGAL.
- RST: all outputs 0. Next state is FETCH.
- FETCH: adr_src=0, a=00, b=10, add, result_src=10. ir_write and pc_write are asserted only in the cycle the access completes: always when MEM_WAIT=0, and when mem_ready=1 otherwise. Next state is DECODE on completion; otherwise stay in FETCH.
- DECODE: a=01, b=01, add (branch/JAL target). Next state by opcode:
  - 0000011 and 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - Any other opcode → ILLEGAL.
- MEMADR: a=10, b=01, add. Next state is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits like FETCH, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state is FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held high for the whole wait. Next state is FETCH on completion.
- EXECR: a=10, b=00, alu_ctrl from funct3, then ALUWB. funct7b5=1 with funct3=000 selects sub.
- EXECI: a=10, b=01, alu_ctrl from funct3, then ALUWB. funct7b5 is ignored (no subi).
- funct3 mapping: 000 add/sub, 010 slt, 110 or, 111 and. Any other funct3 gives add.
- ALUWB: result_src=00, reg_write=1. Next state is FETCH.
- BEQ: a=10, b=00, sub, result_src=00. pc_write = zero (combinational, Mealy). Next state is FETCH.
- JALR: a=10, b=01, add (target into ALUOut). Next state is JAL.
- JAL: a=01, b=10, add, result_src=00, pc_write=1 (PC ← ALUOut target). Next state is ALUWB (rd ← OldPC+4).
- ILLEGAL: all strobes 0, illegal=1. The FSM stays here until reset.
- Unlisted outputs in any state are 0; the 2-bit fields are 00.

## Timing

- Every output is a function of the current state, plus mem_ready (FETCH, MEMREAD, MEMWRITE) and zero (BEQ). No output is registered.
- Reset: the state is RST immediately and asynchronously. All outputs, including illegal, go to 0. The first FETCH is on the first clock edge after rst_n rises.
- Cycles per instruction with MEM_WAIT=0: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, jalr 5.
- Each cycle with mem_ready=0 in a wait state adds one cycle when MEM_WAIT=1.
- mem_ready=1 arriving on the first cycle of a wait state completes the access with no stall.
- rst_n asserted mid-instruction aborts the instruction. Any mem_write/reg_write in progress drops within the same cycle.

## Test plan

- Reset, then an R-type add (op=0110011, funct3=000, funct7b5=0), MEM_WAIT=0 → states RST, FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in ALUWB; alu_ctrl=000 in EXECR.
- sub and slt: funct7b5=1/funct3=000 → alu_ctrl=001. funct3=010 → 101. I-type with funct7b5=1, funct3=000 → 000.
- lw with MEM_WAIT=1 and mem_ready low for 3 cycles in MEMREAD → MEMREAD lasts 4 cycles; adr_src=1 throughout; MEMWB then has result_src=01 and reg_write=1.
- sw with MEM_WAIT=1, mem_ready=0 for 2 cycles → mem_write=1 for 3 consecutive cycles, then FETCH.
- beq: zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0. 3 cycles total each.
- jalr (5 cycles: pc_write in JAL, reg_write in ALUWB), then op=1111111 → ILLEGAL with illegal=1 held for 10 cycles; rst_n low clears it asynchronously.
